// File: rtl/rob_commit_sequencer_if.sv
// rtl/rob_commit_sequencer_if.sv - retire lanes, ARF write port and snoop bundle of the commit sequencer
interface rob_commit_sequencer_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int AREG_W       = 5
);
  logic [COMMIT_WIDTH-1:0]             cm_valid;
  logic [COMMIT_WIDTH-1:0]             cm_has_dst;
  logic [COMMIT_WIDTH-1:0][AREG_W-1:0] cm_dst_index;
  logic [COMMIT_WIDTH-1:0][31:0]       cm_dst_val;
  logic                                cm_ready;
  logic                                rob_valid;
  logic [AREG_W-1:0]                   rob_dst_index;
  logic [31:0]                         rob_dst_val;
  logic [AREG_W-1:0]                   snoop_index;
  logic                                snoop_hit;
  logic [31:0]                         snoop_val;
  logic                                empty;

  modport master (
    output cm_valid, cm_has_dst, cm_dst_index, cm_dst_val, snoop_index,
    input  cm_ready, rob_valid, rob_dst_index, rob_dst_val, snoop_hit, snoop_val, empty
  );

  modport slave (
    input  cm_valid, cm_has_dst, cm_dst_index, cm_dst_val, snoop_index,
    output cm_ready, rob_valid, rob_dst_index, rob_dst_val, snoop_hit, snoop_val, empty
  );
endinterface

// File: rtl/rob_commit_sequencer.sv
// rtl/rob_commit_sequencer.sv - funnels up to COMMIT_WIDTH retiring writes per cycle onto one ARF write port
module rob_commit_sequencer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 4,
  parameter int NUM_AREGS    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rob_commit_sequencer_if.slave bus
);
  localparam int AREG_W = $clog2(NUM_AREGS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [AREG_W-1:0] idx_q [DEPTH];
  logic [31:0]       val_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              rob_valid_q;
  logic [AREG_W-1:0] rob_idx_q;
  logic [31:0]       rob_val_q;

  logic                    accept;
  logic                    pop;
  logic                    byp_valid;
  logic [AREG_W-1:0]       byp_idx;
  logic [31:0]             byp_val;
  logic [COMMIT_WIDTH-1:0] wr_en;
  logic [PTR_W-1:0]        wr_ptr [COMMIT_WIDTH];
  logic [CNT_W-1:0]        push_cnt;
  logic                    snoop_hit;
  logic [31:0]             snoop_val;

  // Credit comes from the registered count only, so a same-cycle pop never widens acceptance.
  assign accept = count_q <= CNT_W'(DEPTH - COMMIT_WIDTH);
  assign pop    = count_q != '0;

  always_comb begin
    byp_valid = 1'b0;
    byp_idx   = '0;
    byp_val   = '0;
    wr_en     = '0;
    push_cnt  = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      wr_ptr[i] = tail_q;
      if (bus.cm_valid[i] && accept && bus.cm_has_dst[i] && (bus.cm_dst_index[i] != '0)) begin
        if (!pop && !byp_valid) begin
          byp_valid = 1'b1;
          byp_idx   = bus.cm_dst_index[i];
          byp_val   = bus.cm_dst_val[i];
        end else begin
          wr_en[i]  = 1'b1;
          wr_ptr[i] = tail_q + push_cnt[PTR_W-1:0];
          push_cnt  = push_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rob_valid_q <= 1'b0;
      rob_idx_q   <= '0;
      rob_val_q   <= '0;
    end else begin
      if (pop) begin
        rob_valid_q <= 1'b1;
        rob_idx_q   <= idx_q[head_q];
        rob_val_q   <= val_q[head_q];
        head_q      <= head_q + PTR_W'(1);
      end else if (byp_valid) begin
        rob_valid_q <= 1'b1;
        rob_idx_q   <= byp_idx;
        rob_val_q   <= byp_val;
      end else begin
        rob_valid_q <= 1'b0;
      end
      tail_q  <= tail_q + push_cnt[PTR_W-1:0];
      count_q <= count_q + push_cnt - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (wr_en[i]) begin
        idx_q[wr_ptr[i]] <= bus.cm_dst_index[i];
        val_q[wr_ptr[i]] <= bus.cm_dst_val[i];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching write wins.
  always_comb begin
    snoop_hit = 1'b0;
    snoop_val = '0;
    if (bus.snoop_index != '0) begin
      if (rob_valid_q && (rob_idx_q == bus.snoop_index)) begin
        snoop_hit = 1'b1;
        snoop_val = rob_val_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CNT_W'(k) < count_q) && (idx_q[head_q + PTR_W'(k)] == bus.snoop_index)) begin
          snoop_hit = 1'b1;
          snoop_val = val_q[head_q + PTR_W'(k)];
        end
      end
    end
  end

  assign bus.cm_ready      = accept;
  assign bus.rob_valid     = rob_valid_q;
  assign bus.rob_dst_index = rob_idx_q;
  assign bus.rob_dst_val   = rob_val_q;
  assign bus.snoop_hit     = snoop_hit;
  assign bus.snoop_val     = snoop_val;
  assign bus.empty         = (count_q == '0) && !rob_valid_q;
endmodule

// File: tb/tb_rob_commit_sequencer.sv
// tb/tb_rob_commit_sequencer.sv - self-checking bench for rob_commit_sequencer
module tb_rob_commit_sequencer;
  localparam int CW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] val;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  wr_t         mq[$];
  bit          m_rv = 1'b0;
  logic [4:0]  m_ridx = '0;
  logic [31:0] m_rval = '0;

  always #5 clk = ~clk;

  rob_commit_sequencer_if #(.COMMIT_WIDTH(CW), .AREG_W(5)) bus ();

  rob_commit_sequencer #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH), .NUM_AREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: pending writes are a plain queue; output slot takes the oldest pending write.
  task automatic drive(input logic [1:0] v, input logic [1:0] hd, input logic [4:0] i0,
                       input logic [4:0] i1, input logic [31:0] d0, input logic [31:0] d1);
    wr_t acc[$];
    wr_t h;
    bus.cm_valid        = v;
    bus.cm_has_dst      = hd;
    bus.cm_dst_index[0] = i0;
    bus.cm_dst_index[1] = i1;
    bus.cm_dst_val[0]   = d0;
    bus.cm_dst_val[1]   = d1;
    if ((DEPTH - mq.size()) >= CW) begin
      if (v[0] && hd[0] && i0 != 0) begin h.idx = i0; h.val = d0; acc.push_back(h); end
      if (v[1] && hd[1] && i1 != 0) begin h.idx = i1; h.val = d1; acc.push_back(h); end
    end
    if (mq.size() > 0) begin
      h = mq.pop_front();
      m_rv = 1'b1; m_ridx = h.idx; m_rval = h.val;
    end else if (acc.size() > 0) begin
      h = acc.pop_front();
      m_rv = 1'b1; m_ridx = h.idx; m_rval = h.val;
    end else begin
      m_rv = 1'b0;
    end
    foreach (acc[n]) mq.push_back(acc[n]);
    @(posedge clk);
    #1;
  endtask

  function automatic void model_snoop(input logic [4:0] s, output bit hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (s == 0) return;
    for (int k = mq.size() - 1; k >= 0; k--) begin
      if (mq[k].idx == s) begin hit = 1'b1; val = mq[k].val; return; end
    end
    if (m_rv && m_ridx == s) begin hit = 1'b1; val = m_rval; end
  endfunction

  task automatic test_reset();
    bus.snoop_index = 5'd3;
    #12;
    checks++; if (bus.rob_valid !== 1'b0) begin failures++; $display("FAIL reset_rob_valid got=%0b exp=0", bus.rob_valid); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL reset_cm_ready got=%0b exp=1", bus.cm_ready); end
    checks++; if (bus.snoop_hit !== 1'b0) begin failures++; $display("FAIL reset_snoop_hit got=%0b exp=0", bus.snoop_hit); end
    checks++; if (bus.rob_dst_index !== 5'd0 || bus.rob_dst_val !== 32'd0) begin
      failures++; $display("FAIL reset_rob_data got=%0d/%h exp=0/0", bus.rob_dst_index, bus.rob_dst_val);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    drive(2'b01, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    checks++; if (bus.rob_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%0b exp=1", bus.rob_valid); end
    checks++; if (bus.rob_dst_index !== 5'd5) begin failures++; $display("FAIL bypass_idx got=%0d exp=5", bus.rob_dst_index); end
    checks++; if (bus.rob_dst_val !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_val got=%h exp=deadbeef", bus.rob_dst_val); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL bypass_empty_busy got=%0b exp=0", bus.empty); end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    checks++; if (bus.rob_valid !== 1'b0) begin failures++; $display("FAIL bypass_after_valid got=%0b exp=0", bus.rob_valid); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL bypass_after_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.rob_dst_index !== 5'd5) begin failures++; $display("FAIL bypass_hold_idx got=%0d exp=5", bus.rob_dst_index); end
  endtask

  task automatic test_filter();
    drive(2'b11, 2'b01, 5'd0, 5'd9, 32'h1111, 32'h2222);
    checks++; if (bus.rob_valid !== 1'b0) begin failures++; $display("FAIL filter_valid got=%0b exp=0", bus.rob_valid); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL filter_empty got=%0b exp=1", bus.empty); end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    checks++; if (bus.rob_valid !== 1'b0) begin failures++; $display("FAIL filter_late_valid got=%0b exp=0", bus.rob_valid); end
  endtask

  // Pairs of writes per cycle until backpressure, then collect everything issued to the ARF.
  task automatic run_burst(input string tag, input logic [4:0] base, input logic [31:0] vbase);
    wr_t obs[$];
    wr_t h;
    for (int c = 0; c < 4; c++) begin
      logic [4:0] a = base + 5'(2 * c);
      drive(2'b11, 2'b11, a, a + 5'd1, vbase + 32'(2 * c), vbase + 32'(2 * c + 1));
      if (bus.rob_valid) begin h.idx = bus.rob_dst_index; h.val = bus.rob_dst_val; obs.push_back(h); end
      if (c == 1) begin
        checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_cnt2 got=%0b exp=1", tag, bus.cm_ready); end
      end
      if (c == 2) begin
        checks++; if (bus.cm_ready !== 1'b0) begin failures++; $display("FAIL %s_ready_cnt3 got=%0b exp=0", tag, bus.cm_ready); end
      end
    end
    for (int c = 0; c < 8; c++) begin
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      if (bus.rob_valid) begin h.idx = bus.rob_dst_index; h.val = bus.rob_dst_val; obs.push_back(h); end
    end
    checks++; if (obs.size() != 6) begin failures++; $display("FAIL %s_write_count got=%0d exp=6", tag, obs.size()); end
    for (int n = 0; n < 6 && n < obs.size(); n++) begin
      checks++;
      if (obs[n].idx !== base + 5'(n) || obs[n].val !== vbase + 32'(n)) begin
        failures++;
        $display("FAIL %s_order[%0d] got=%0d/%h exp=%0d/%h", tag, n, obs[n].idx, obs[n].val, base + 5'(n), vbase + 32'(n));
      end
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL %s_drained_empty got=%0b exp=1", tag, bus.empty); end
  endtask

  task automatic test_full();
    run_burst("full", 5'd1, 32'h100);
  endtask

  task automatic test_simultaneous();
    run_burst("simul", 5'd10, 32'hA000_0000);
  endtask

  task automatic test_snoop();
    bus.snoop_index = 5'd7;
    drive(2'b11, 2'b11, 5'd7, 5'd7, 32'd1, 32'd2);
    checks++; if (bus.snoop_hit !== 1'b1 || bus.snoop_val !== 32'd2) begin
      failures++; $display("FAIL snoop_young got=%0b/%0d exp=1/2", bus.snoop_hit, bus.snoop_val);
    end
    bus.snoop_index = 5'd0;
    #1;
    checks++; if (bus.snoop_hit !== 1'b0) begin failures++; $display("FAIL snoop_x0 got=%0b exp=0", bus.snoop_hit); end
    bus.snoop_index = 5'd7;
    drive(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    checks++; if (bus.snoop_hit !== 1'b1 || bus.snoop_val !== 32'd2) begin
      failures++; $display("FAIL snoop_rob got=%0b/%0d exp=1/2", bus.snoop_hit, bus.snoop_val);
    end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    checks++; if (bus.snoop_hit !== 1'b0 || bus.snoop_val !== 32'd0) begin
      failures++; $display("FAIL snoop_drained got=%0b/%0d exp=0/0", bus.snoop_hit, bus.snoop_val);
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44);
    drive(2'b11, 2'b11, 5'd5, 5'd6, 32'h55, 32'h66);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rob_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", bus.rob_valid); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", bus.cm_ready); end
    mq.delete();
    m_rv = 1'b0;
    bus.cm_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      checks++; if (bus.rob_valid !== 1'b0) begin failures++; $display("FAIL midrst_ghost[%0d] got=%0b exp=0", c, bus.rob_valid); end
    end
  endtask

  task automatic test_random();
    bit          e_hit;
    logic [31:0] e_val;
    for (int c = 0; c < 400; c++) begin
      bus.snoop_index = 5'($urandom_range(0, 7));
      drive(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      checks++; if (bus.rob_valid !== m_rv) begin failures++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", c, bus.rob_valid, m_rv); end
      if (m_rv) begin
        checks++;
        if (bus.rob_dst_index !== m_ridx || bus.rob_dst_val !== m_rval) begin
          failures++; $display("FAIL rnd_data[%0d] got=%0d/%h exp=%0d/%h", c, bus.rob_dst_index, bus.rob_dst_val, m_ridx, m_rval);
        end
      end
      checks++; if (bus.cm_ready !== ((DEPTH - mq.size()) >= CW)) begin
        failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", c, bus.cm_ready, (DEPTH - mq.size()) >= CW);
      end
      checks++; if (bus.empty !== (mq.size() == 0 && !m_rv)) begin
        failures++; $display("FAIL rnd_empty[%0d] got=%0b exp=%0b", c, bus.empty, mq.size() == 0 && !m_rv);
      end
      model_snoop(bus.snoop_index, e_hit, e_val);
      checks++; if (bus.snoop_hit !== e_hit || bus.snoop_val !== e_val) begin
        failures++; $display("FAIL rnd_snoop[%0d] got=%0b/%h exp=%0b/%h", c, bus.snoop_hit, bus.snoop_val, e_hit, e_val);
      end
    end
  endtask

  initial begin
    bus.cm_valid     = '0;
    bus.cm_has_dst   = '0;
    bus.cm_dst_index = '0;
    bus.cm_dst_val   = '0;
    bus.snoop_index  = '0;
    test_reset();
    test_bypass();
    test_filter();
    test_full();
    test_snoop();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
